// File: rtl/systolic_array_ctrl_pkg.sv
// rtl/systolic_array_ctrl_pkg.sv - shared types and constants for the systolic array tile sequencer
// Package systolic_pkg: default array geometry, controller state encoding and
// the array pipeline latency (ARRAY_LAT = ARRAY_HEIGHT + ARRAY_WIDTH - 1).
package systolic_pkg;

    localparam int DEF_ARRAY_HEIGHT = 4;
    localparam int DEF_ARRAY_WIDTH  = 4;
    localparam int DEF_MAX_VECS     = 256;

    function automatic int array_lat(input int height, input int width);
        return height + width - 1;
    endfunction

    localparam int ARRAY_LAT = array_lat(DEF_ARRAY_HEIGHT, DEF_ARRAY_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// rtl/systolic_array_ctrl_if.sv - host start/done handshake for the tile sequencer
// Signals: start (host -> ctrl), num_vecs (host -> ctrl, VW bits),
//          busy (ctrl -> host), done (ctrl -> host, one-cycle pulse).
// Modports: master = host side, slave = controller side.
interface systolic_array_ctrl_if
    import systolic_pkg::*;
#(
    parameter int VW = $clog2(DEF_MAX_VECS + 1)
) ();
    logic          start;
    logic [VW-1:0] num_vecs;
    logic          busy;
    logic          done;

    modport master (output start, output num_vecs, input busy, input done);
    modport slave  (input start, input num_vecs, output busy, output done);
endinterface

// File: rtl/systolic_array_ctrl_ofmap_wr_sched.sv
// rtl/systolic_array_ctrl_ofmap_wr_sched.sv - turns the ifmap issue window into the ofmap write window
// Ports: clk, rst (sync, active-high), clear (tile start, resets the row
//        address), issue (ifmap read strobe), wr_en / addr (ofmap write strobe
//        and row address), last_wr (this write has nothing behind it).
// A write comes out LAT+1 cycles after each issue: one cycle of buffer read
// latency plus LAT cycles through the array.
module ofmap_wr_sched
    import systolic_pkg::*;
#(
    parameter int LAT = ARRAY_LAT,
    parameter int VW  = $clog2(DEF_MAX_VECS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          issue,
    output logic          wr_en,
    output logic [VW-1:0] addr,
    output logic          last_wr
);
    // sr[0] is the newest issue, sr[LAT] the one whose result is ready now
    logic [LAT:0]  sr;
    logic [VW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr <= {sr[LAT-1:0], issue};
            if (clear)
                cnt <= '0;
            else if (sr[LAT])
                cnt <= cnt + VW'(1);
        end
    end

    assign wr_en   = sr[LAT];
    assign addr    = cnt;
    // Only meaningful once issuing has stopped: no later results are in flight
    assign last_wr = sr[LAT] & ~(|sr[LAT-1:0]);
endmodule

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - one-tile sequencer: load weights, stream ifmaps, drain, commit ofmap rows
// Ports: clk, rst (sync, active-high); host (start/num_vecs/busy/done);
//        weight_rd_en/weight_row/weight_load (weight buffer and array load);
//        ifmap_rd_en/ifmap_addr (ifmap buffer); array_enable (array step);
//        ofmap_wr_en/ofmap_addr (ofmap buffer).
// Optional: SYSTOLIC_CTRL_PERF_EN adds perf_cycles[31:0], the busy cycle
//           count of the current/last tile (cleared on accepted start).
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
    parameter int ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
    parameter int MAX_VECS     = DEF_MAX_VECS,
    localparam int VW          = $clog2(MAX_VECS + 1),
    localparam int RW          = $clog2(ARRAY_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_array_ctrl_if.slave host,
    output logic                 weight_rd_en,
    output logic [RW-1:0]        weight_row,
    output logic                 weight_load,
    output logic                 ifmap_rd_en,
    output logic [VW-1:0]        ifmap_addr,
    output logic                 array_enable,
    output logic                 ofmap_wr_en,
    output logic [VW-1:0]        ofmap_addr
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);
    localparam int LAT = array_lat(ARRAY_HEIGHT, ARRAY_WIDTH);

    ctrl_state_e   state_q, state_d;
    logic [RW-1:0] wcnt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] nv_q;
    logic [VW-1:0] nv_in;
    logic          accept;
    logic          last_wr;
    logic          busy_c, done_c;

    // Out-of-range vector counts are clamped rather than trusted
    assign nv_in  = (host.num_vecs > VW'(MAX_VECS)) ? VW'(MAX_VECS) : host.num_vecs;
    assign accept = (state_q == IDLE) && host.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt        <= '0;
            vcnt        <= '0;
            nv_q        <= '0;
            weight_load <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Weight buffer has one cycle of read latency
            weight_load <= weight_rd_en;
            case (state_q)
                IDLE: begin
                    if (host.start) begin
                        nv_q <= nv_in;
                        wcnt <= '0;
                        vcnt <= '0;
                    end
                end
                LOAD_W: if (wcnt != RW'(ARRAY_HEIGHT - 1)) wcnt <= wcnt + RW'(1);
                STREAM: if (vcnt != nv_q - VW'(1)) vcnt <= vcnt + VW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        busy_c       = (state_q != IDLE);
        done_c       = 1'b0;
        weight_rd_en = 1'b0;
        weight_row   = '0;
        ifmap_rd_en  = 1'b0;
        ifmap_addr   = '0;
        array_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.start) state_d = LOAD_W;
            end
            LOAD_W: begin
                weight_rd_en = 1'b1;
                weight_row   = wcnt;
                if (wcnt == RW'(ARRAY_HEIGHT - 1))
                    state_d = (nv_q == '0) ? DONE : STREAM;
            end
            STREAM: begin
                ifmap_rd_en  = 1'b1;
                ifmap_addr   = vcnt;
                // The first vector is still in the buffer read stage
                array_enable = (vcnt != '0);
                if (vcnt == nv_q - VW'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                array_enable = 1'b1;
                if (last_wr) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign host.busy = busy_c;
    assign host.done = done_c;

    ofmap_wr_sched #(
        .LAT (LAT),
        .VW  (VW)
    ) u_ofmap_wr_sched (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .issue   (ifmap_rd_en),
        .wr_en   (ofmap_wr_en),
        .addr    (ofmap_addr),
        .last_wr (last_wr)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_cycles <= '0;
        else if (accept)
            perf_cycles <= '0;
        else if (busy_c && (perf_cycles != 32'hFFFF_FFFF))
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif
endmodule
